// File: rtl/mem_to_uart_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_to_uart_if
//  Description : Read-side RAM port bundle (req/gnt/rvalid protocol) shared
//                between the mem_to_uart initiator and the RAM it reads.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals (named from the initiator's point of view)
//    data_req_o     request, held until granted
//    data_addr_o    word-aligned byte address
//    data_be_o      byte enables
//    data_we_o      write enable (always 0 from this initiator)
//    data_wdata_o   write data   (always 0 from this initiator)
//    data_gnt_i     grant
//    data_rvalid_i  read data valid
//    data_rdata_i   read data
// ============================================================================
interface mem_to_uart_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  data_req_o;
  logic [ADDR_WIDTH-1:0] data_addr_o;
  logic [3:0]            data_be_o;
  logic                  data_we_o;
  logic [31:0]           data_wdata_o;
  logic                  data_gnt_i;
  logic                  data_rvalid_i;
  logic [31:0]           data_rdata_i;

  modport master (
    output data_req_o, data_addr_o, data_be_o, data_we_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_be_o, data_we_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/mem_to_uart.sv
`default_nettype none
// ============================================================================
//  Module      : mem_to_uart
//  Description : Reads a block of 32-bit words from RAM and streams them out
//                as little-endian 8N1 UART bytes (memory dump to host).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i         clock, rising edge
//    rst_i         asynchronous active-high reset
//    start_i       one-cycle start pulse, honoured only when idle
//    start_addr_i  first byte address (low two bits ignored)
//    word_count_i  number of 32-bit words to send (0 = finish immediately)
//    bus           RAM read port (master side)
//    tx_o          UART serial output, idles high
//    busy_o        high from start acceptance until done
//    done_o        one-cycle pulse at end of transfer
// ============================================================================
module mem_to_uart #(
  parameter int ADDR_WIDTH   = 12,
  parameter int CNT_WIDTH    = 10,
  parameter int CLKS_PER_BIT = 868
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_i,
  input  wire logic                  start_i,
  input  wire logic [ADDR_WIDTH-1:0] start_addr_i,
  input  wire logic [CNT_WIDTH-1:0]  word_count_i,
  mem_to_uart_if.master              bus,
  output logic                       tx_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int                    TIMER_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_W-1:0]    LAST_TICK = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_TX   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  state_q;
  logic                    req_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_WIDTH-1:0]    cnt_q;     // words still to send, including current
  logic [31:0]             data_q;
  logic [TIMER_W-1:0]      timer_q;
  logic [3:0]              bit_q;     // 0 = start, 1..8 = data, 9 = stop
  logic [1:0]              byte_q;    // byte lane within data_q
  logic                    tx_q;
  logic                    busy_q;
  logic                    done_q;

  logic [7:0]              w_cur_byte;
  logic                    w_next_bit;

  // Value of the bit that follows bit_q within the current byte frame:
  // bit_q=k (0..7) is followed by data bit k, bit_q=8 by the stop bit.
  always_comb begin
    w_cur_byte = data_q[{byte_q, 3'b000} +: 8];
    w_next_bit = (bit_q == 4'd8) ? 1'b1 : w_cur_byte[bit_q[2:0]];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      timer_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q <= start_addr_i & WORD_MASK;
            cnt_q  <= word_count_i;
            busy_q <= 1'b1;
            if (word_count_i == '0) begin
              state_q <= S_DONE;
            end else begin
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (bus.data_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.data_rvalid_i) begin
            data_q  <= bus.data_rdata_i;
            tx_q    <= 1'b0;          // start bit of byte 0
            timer_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            state_q <= S_TX;
          end
        end

        S_TX: begin
          if (timer_q == LAST_TICK) begin
            timer_q <= '0;
            if (bit_q == 4'd9) begin
              bit_q <= '0;
              if (byte_q == 2'd3) begin
                // Stop bit of the last byte has ended: word finished.
                byte_q <= '0;
                tx_q   <= 1'b1;
                cnt_q  <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                  state_q <= S_DONE;
                end else begin
                  addr_q  <= addr_q + WORD_STEP;
                  req_q   <= 1'b1;
                  state_q <= S_REQ;
                end
              end else begin
                // Next byte starts immediately, no idle gap.
                byte_q <= byte_q + 2'd1;
                tx_q   <= 1'b0;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
              tx_q  <= w_next_bit;
            end
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.data_req_o   = req_q;
  assign bus.data_addr_o  = addr_q;
  assign bus.data_be_o    = 4'b1111;
  assign bus.data_we_o    = 1'b0;
  assign bus.data_wdata_o = 32'h0;

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_to_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_to_uart
//  Description : Self-checking bench for mem_to_uart with CLKS_PER_BIT=4.
//                A timeline model predicts every output per cycle from the
//                transfer parameters; a UART decoder and grant-address log
//                are compared against hand-computed literals.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_to_uart;

  localparam int AW  = 12;
  localparam int CW  = 10;
  localparam int CPB = 4;
  localparam int WORD_CYC = 40 * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] start_addr_i = '0;
  logic [CW-1:0] word_count_i = '0;
  logic          tx_o, busy_o, done_o;

  mem_to_uart_if #(.ADDR_WIDTH(AW)) ram_bus ();

  mem_to_uart #(
    .ADDR_WIDTH  (AW),
    .CNT_WIDTH   (CW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start_i),
    .start_addr_i(start_addr_i),
    .word_count_i(word_count_i),
    .bus         (ram_bus),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // RAM contents and responder configuration
  logic [31:0] mem [1024];
  int gd = 0;        // grant delay after req rises
  int rd = 1;        // rvalid delay after grant
  bit spur = 1'b0;   // inject stray rvalid pulses outside WAIT

  // Timeline model
  int          m_req_from, m_rv_cyc, m_tx_s, m_done_cyc, m_busy_from, m_left, m_idx;
  logic [AW-1:0] m_base;
  logic [31:0]   m_word;
  logic          e_req, e_tx, e_done, e_busy;
  logic [AW-1:0] e_addr;
  bit            chk_en = 1'b0;

  // Observations from the DUT for literal checks
  int          dut_done_cyc = -1;
  logic [7:0]  rxq [$];
  logic [AW-1:0] gaddr_q [$];
  int          rx_t = -1;
  logic [7:0]  rx_b;

  // Serial frame bit n (0..39) for a word: 10-bit frames, byte 0 first.
  function automatic logic frame_bit(input logic [31:0] w, input int n);
    int byt, b;
    byt = n / 10;
    b   = n % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return w[byt*8 + b - 1];
  endfunction

  task automatic clear_model();
    m_req_from  = -1;
    m_rv_cyc    = -1;
    m_tx_s      = -1;
    m_done_cyc  = -1;
    m_busy_from = -1;
    m_left      = 0;
    m_idx       = 0;
    e_req  = 1'b0;
    e_tx   = 1'b1;
    e_done = 1'b0;
    e_busy = 1'b0;
  endtask

  // Advance one cycle: drive the RAM side and compute this cycle's expectations.
  task automatic tick();
    @(posedge clk);
    #1;
    start_i                = 1'b0;
    ram_bus.data_gnt_i     = 1'b0;
    ram_bus.data_rvalid_i  = 1'b0;
    ram_bus.data_rdata_i   = 32'h0;
    e_req  = (m_req_from >= 0) && (cyc >= m_req_from);
    e_addr = m_base + AW'(4 * m_idx);
    if (e_req && cyc == m_req_from + gd) begin
      ram_bus.data_gnt_i = 1'b1;
      m_rv_cyc   = cyc + rd;
      m_req_from = -1;
      if (spur && rd > 1) begin
        ram_bus.data_rvalid_i = 1'b1;
        ram_bus.data_rdata_i  = 32'hDEADBEEF;
      end
    end else if (spur && e_req && cyc == m_req_from) begin
      ram_bus.data_rvalid_i = 1'b1;
      ram_bus.data_rdata_i  = 32'hDEADBEEF;
    end
    if (spur && m_tx_s >= 0 && cyc == m_tx_s + 20) begin
      ram_bus.data_rvalid_i = 1'b1;
      ram_bus.data_rdata_i  = 32'hCAFEF00D;
    end
    if (cyc == m_rv_cyc) begin
      ram_bus.data_rvalid_i = 1'b1;
      ram_bus.data_rdata_i  = mem[e_addr[AW-1:2]];
      m_word   = mem[e_addr[AW-1:2]];
      m_tx_s   = cyc + 1;
      m_rv_cyc = -1;
      m_idx++;
      m_left--;
      if (m_left == 0) m_done_cyc = m_tx_s + WORD_CYC + 1;
      else             m_req_from = m_tx_s + WORD_CYC;
    end
    e_tx   = (m_tx_s >= 0 && cyc >= m_tx_s && cyc < m_tx_s + WORD_CYC)
             ? frame_bit(m_word, (cyc - m_tx_s) / CPB) : 1'b1;
    e_done = (cyc == m_done_cyc);
    e_busy = (m_busy_from >= 0) && (cyc >= m_busy_from) &&
             (m_done_cyc < 0 || cyc < m_done_cyc);
  endtask

  task automatic start_xfer(input logic [AW-1:0] a, input int n);
    start_i      = 1'b1;
    start_addr_i = a;
    word_count_i = CW'(n);
    m_base       = a & ~AW'(3);
    m_idx        = 0;
    m_left       = n;
    m_busy_from  = cyc + 1;
    m_tx_s       = -1;
    m_rv_cyc     = -1;
    if (n == 0) begin
      m_done_cyc = cyc + 2;
      m_req_from = -1;
    end else begin
      m_done_cyc = -1;
      m_req_from = cyc + 1;
    end
    rxq.delete();
    gaddr_q.delete();
    dut_done_cyc = -1;
  endtask

  task automatic run_to_idle();
    int n = 0;
    while (!(m_done_cyc >= 0 && cyc > m_done_cyc + 2)) begin
      tick();
      n++;
      if (n > 3000) begin
        n_err++;
        $display("FAIL idle_timeout cyc=%0d got=running expected=idle", cyc);
        return;
      end
    end
  endtask

  task automatic check_bytes(input string nm, input logic [63:0] exp, input int n);
    chk({nm, "_nbytes"}, rxq.size(), n);
    for (int i = 0; i < n && i < rxq.size(); i++)
      chk({nm, "_byte"}, rxq[i], exp[8*i +: 8]);
  endtask

  task automatic check_gaddr(input string nm, input logic [23:0] exp, input int n);
    chk({nm, "_ngnt"}, gaddr_q.size(), n);
    for (int i = 0; i < n && i < gaddr_q.size(); i++)
      chk({nm, "_gaddr"}, gaddr_q[i], exp[12*i +: 12]);
  endtask

  // Per-cycle compare against the model, plus UART decode and grant log.
  always @(negedge clk) begin
    if (rst) rx_t = -1;
    if (chk_en) begin
      chk("tx",   tx_o,                 e_tx);
      chk("req",  ram_bus.data_req_o,   e_req);
      chk("done", done_o,               e_done);
      chk("busy", busy_o,               e_busy);
      chk("be_we", {ram_bus.data_be_o, ram_bus.data_we_o}, 5'b11110);
      chk("wdata", ram_bus.data_wdata_o, 32'h0);
      if (e_req && ram_bus.data_req_o) chk("addr", ram_bus.data_addr_o, e_addr);
      if (done_o) dut_done_cyc = cyc;
      if (ram_bus.data_req_o && ram_bus.data_gnt_i) gaddr_q.push_back(ram_bus.data_addr_o);
      if (!rst) begin
        if (rx_t < 0) begin
          if (tx_o == 1'b0) begin
            rx_t = 0;
            rx_b = 8'h00;
          end
        end else begin
          rx_t++;
          if (rx_t % CPB == CPB / 2) begin
            if (rx_t / CPB >= 1 && rx_t / CPB <= 8) rx_b[rx_t / CPB - 1] = tx_o;
            if (rx_t / CPB == 9) begin
              rxq.push_back(rx_b);
              rx_t = -1;
            end
          end
        end
      end
    end
  end

  int t0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[12'h010 >> 2] = 32'h44332211;
    mem[12'hFFC >> 2] = 32'hA1B2C3D4;
    mem[12'h000 >> 2] = 32'h0F1E2D3C;
    mem[12'h020 >> 2] = 32'h80FF0155;
    mem[12'h100 >> 2] = 32'h99999999;
    ram_bus.data_gnt_i    = 1'b0;
    ram_bus.data_rvalid_i = 1'b0;
    ram_bus.data_rdata_i  = 32'h0;
    m_base = '0;
    m_word = '0;
    e_addr = '0;
    clear_model();

    // Reset state
    tick();
    chk_en = 1'b1;
    repeat (3) tick();
    chk("rst_tx",   tx_o, 1'b1);
    chk("rst_req",  ram_bus.data_req_o, 1'b0);
    chk("rst_addr", ram_bus.data_addr_o, 12'h000);
    chk("rst_busy", busy_o, 1'b0);
    rst = 1'b0;
    repeat (3) tick();

    // Single word, immediate grant, rvalid one cycle later
    gd = 0; rd = 1; spur = 1'b0;
    tick(); t0 = cyc; start_xfer(12'h010, 1);
    run_to_idle();
    chk("single_done_lat", dut_done_cyc - t0, 164);
    check_bytes("single", 64'h44332211, 4);
    check_gaddr("single", 24'h010, 1);

    // Zero count
    tick(); t0 = cyc; start_xfer(12'h123, 0);
    run_to_idle();
    chk("zero_done_lat", dut_done_cyc - t0, 2);
    check_gaddr("zero", 24'h0, 0);
    check_bytes("zero", 64'h0, 0);

    // Unaligned start near the top: word address wraps
    tick(); t0 = cyc; start_xfer(12'hFFE, 2);
    run_to_idle();
    chk("wrap_done_lat", dut_done_cyc - t0, 326);
    check_gaddr("wrap", {12'h000, 12'hFFC}, 2);
    check_bytes("wrap", 64'h0F1E2D3C_A1B2C3D4, 8);

    // Back-pressure with stray rvalid pulses
    gd = 3; rd = 5; spur = 1'b1;
    tick(); t0 = cyc; start_xfer(12'h020, 1);
    run_to_idle();
    chk("bp_done_lat", dut_done_cyc - t0, 171);
    check_bytes("bp", 64'h80FF0155, 4);
    check_gaddr("bp", 24'h020, 1);

    // Start pulse during TX is ignored
    gd = 0; rd = 1; spur = 1'b0;
    tick(); t0 = cyc; start_xfer(12'h010, 1);
    while (cyc < t0 + 33) tick();
    start_i = 1'b1; start_addr_i = 12'h100; word_count_i = CW'(3);
    run_to_idle();
    chk("busy_start_done_lat", dut_done_cyc - t0, 164);
    check_bytes("busy_start", 64'h44332211, 4);
    check_gaddr("busy_start", 24'h010, 1);

    // Reset during data bit 3 of byte 1 (0x22 -> bit value 0)
    tick(); t0 = cyc; start_xfer(12'h010, 1);
    while (cyc < t0 + 3 + 57) tick();
    #1;
    chk("pre_rst_tx", tx_o, 1'b0);
    rst = 1'b1;
    clear_model();
    #1;
    chk("async_rst_tx",   tx_o, 1'b1);
    chk("async_rst_req",  ram_bus.data_req_o, 1'b0);
    chk("async_rst_busy", busy_o, 1'b0);
    chk("async_rst_done", done_o, 1'b0);
    chk("async_rst_addr", ram_bus.data_addr_o, 12'h000);
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_no_done", dut_done_cyc, 32'hFFFFFFFF);

    // Normal transfer after reset release
    tick(); t0 = cyc; start_xfer(12'hFFD, 1);
    run_to_idle();
    chk("post_rst_done_lat", dut_done_cyc - t0, 164);
    check_bytes("post_rst", 64'hA1B2C3D4, 4);
    check_gaddr("post_rst", 24'hFFC, 1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_to_uart.md
Name: mem_to_uart

Overview:
- Bus initiator that reads a block of 32-bit words from the RAM uart data port and transmits them as bytes over a UART TX line.
- It is the reverse path of the UART memory loader, used to dump memory contents (e.g. results after a run) back to the host.
- It shares the same req/gnt/rvalid RAM port protocol and the same 8N1 UART framing as the loader.

Parameters:
ADDR_WIDTH, 12, byte-address width of the RAM port.
CNT_WIDTH, 10, width of the word-count input.
CLKS_PER_BIT, 868, clk_i cycles per UART bit (100 MHz / 115200); must be >= 2.

Ports:
clk_i  in  1  clock; all logic is on the rising edge
rst_i  in  1  reset, asynchronous and active-high
start_i  in  1  one-cycle start pulse; sampled only in IDLE
start_addr_i  in  ADDR_WIDTH  first byte address; bits [1:0] are ignored (forced to 0)
word_count_i  in  CNT_WIDTH  number of words to send
data_req_o  out  1  RAM request
data_addr_o  out  ADDR_WIDTH  RAM word-aligned byte address
data_be_o  out  4  always 4'b1111
data_we_o  out  1  always 0 (read only)
data_wdata_o  out  32  always 0
data_gnt_i  in  1  RAM grant
data_rvalid_i  in  1  RAM read data valid
data_rdata_i  in  32  RAM read data
tx_o  out  1  UART serial out, idle high
busy_o  out  1  high from start acceptance until done
done_o  out  1  one-cycle pulse at end of transfer

Behaviour:
- Reset (asynchronous, takes effect immediately): tx_o=1, data_req_o=0, data_addr_o=0, busy_o=0, done_o=0; FSM goes to IDLE and all counters clear.
- Reset mid-frame aborts the transfer with no stop bit and no done_o.
- FSM states: IDLE, REQ, WAIT, TX, DONE.
- IDLE, start_i=1: latch start_addr_i with low bits cleared, latch word_count_i, set busy_o=1 the next cycle.
  - If count==0: go to DONE.
  - Otherwise: go to REQ.
- IDLE, start_i=0: stay. start_i in any other state is ignored.
- REQ: data_req_o=1 with data_addr_o stable. Hold both until data_gnt_i=1, then go to WAIT and deassert req the following cycle. data_req_o rises the cycle after start acceptance.
- WAIT: on data_rvalid_i=1, capture data_rdata_i and go to TX. data_rvalid_i is ignored outside WAIT; a rvalid coincident with gnt in REQ is not accepted.
- TX: send 4 bytes, little-endian: rdata[7:0] first, rdata[31:24] last.
  - Each byte is 10 bits: start(0), 8 data bits LSB first, stop(1). Each bit lasts exactly CLKS_PER_BIT cycles.
  - Bytes are sent back-to-back with no idle gap. A word therefore takes 40*CLKS_PER_BIT cycles.
  - The start bit of byte 0 begins the cycle after rvalid is captured.
- After the stop bit of byte 3:
  - Decrement the remaining-word count.
  - If it is nonzero: add 4 to the address (wraps modulo 2^ADDR_WIDTH) and go to REQ.
  - Otherwise: go to DONE.
- DONE: done_o=1 for exactly one cycle, busy_o falls in the same cycle, then go to IDLE.
- tx_o is 1 in every state except during TX bit periods.
- No timeout on gnt/rvalid: the block waits indefinitely.
- Counters: bit timer is clog2(CLKS_PER_BIT) wide; bit index counts 0..9; byte index counts 0..3.

Test Plan:
Use CLKS_PER_BIT=4 for all scenarios.
- Single word: RAM[0x010]=0x44332211, start_addr=0x010, count=1, gnt same cycle as req, rvalid 1 cycle later -> one request at 0x010; tx_o shows bytes 0x11,0x22,0x33,0x44 (160 cycles total); done_o pulses once; busy_o falls with done_o.
- Zero count: start with count=0 -> no data_req_o; done_o pulses 2 cycles after start; tx_o stays 1.
- Wrap and multi-word: start_addr=0xFFE, count=2 -> requests at 0xFFC then 0x000; 8 bytes sent back-to-back.
- Back-pressure: gnt delayed 3 cycles, rvalid delayed 5 cycles -> req and addr held stable until gnt; tx_o stays high until rvalid; rvalid pulses outside WAIT do not start TX.
- Reset mid-byte: assert rst_i during data bit 3 of byte 1 -> tx_o=1 and data_req_o=0 immediately (no clock edge needed); no done_o; a new start after release runs a normal transfer.
- Start while busy: start_i pulsed during TX with a different address -> ignored; the original transfer completes unchanged.
